// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mc_sequencer
// Description : Multi-cycle CPU control sequencer. Walks each instruction
//               through IF / ID / EX / MEM / WB, raising the fetch, cache,
//               ALU and write-back controls, and counts retired
//               instructions. HLT parks the machine in HALT until reset.
//
//   clk          in   clock, rising-edge
//   reset_n      in   asynchronous active-low reset
//   instr_opcode in   [3:0] opcode of the current instruction
//   instr_func   in   [5:0] func field of the current instruction
//   i_ready      in   instruction-cache done (looked at in IF only)
//   d_ready      in   data-cache done (looked at in MEM only)
//   i_readM      out  instruction fetch request
//   ir_write     out  instruction-register load strobe
//   d_readM      out  data read request
//   d_writeM     out  data write request
//   alu_opcode   out  [3:0] ALU opcode select
//   alu_func     out  [5:0] ALU func select
//   alu_src_imm  out  ALU B operand from immediate
//   reg_write    out  register-file write strobe
//   mem_to_reg   out  write-back from load data
//   pc_write     out  PC advance strobe
//   wwd_en       out  output-port latch strobe
//   illegal      out  unsupported-instruction pulse
//   halted       out  CPU halted
//   num_inst     out  [WORD_SIZE-1:0] retired-instruction count
//   state        out  [2:0] current state
//
// Revision    : 1.0 - initial release
// ============================================================================
module mc_sequencer #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           instr_opcode,
    input  logic [5:0]           instr_func,
    input  logic                 i_ready,
    input  logic                 d_ready,
    output logic                 i_readM,
    output logic                 ir_write,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [3:0]           alu_opcode,
    output logic [5:0]           alu_func,
    output logic                 alu_src_imm,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 pc_write,
    output logic                 wwd_en,
    output logic                 illegal,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic [2:0]           state
);

    localparam logic [2:0] c_ST_IF   = 3'd0;
    localparam logic [2:0] c_ST_ID   = 3'd1;
    localparam logic [2:0] c_ST_EX   = 3'd2;
    localparam logic [2:0] c_ST_MEM  = 3'd3;
    localparam logic [2:0] c_ST_WB   = 3'd4;
    localparam logic [2:0] c_ST_HALT = 3'd5;

    localparam logic [3:0] c_OP_ADI  = 4'd4;
    localparam logic [3:0] c_OP_LWD  = 4'd7;
    localparam logic [3:0] c_OP_SWD  = 4'd8;
    localparam logic [3:0] c_OP_RTYP = 4'd15;

    localparam logic [5:0] c_FN_SHR  = 6'd7;
    localparam logic [5:0] c_FN_WWD  = 6'd28;
    localparam logic [5:0] c_FN_HLT  = 6'd29;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [WORD_SIZE-1:0] r_num_inst;
    logic                 w_retire;

    logic w_is_rtype;
    logic w_is_imm;
    logic w_is_lwd;
    logic w_is_swd;
    logic w_is_hlt;
    logic w_is_wwd;
    logic w_is_alu_r;

    // Instruction decode
    assign w_is_rtype = (instr_opcode == c_OP_RTYP);
    assign w_is_imm   = (instr_opcode >= c_OP_ADI) && (instr_opcode <= c_OP_SWD);
    assign w_is_lwd   = (instr_opcode == c_OP_LWD);
    assign w_is_swd   = (instr_opcode == c_OP_SWD);
    assign w_is_hlt   = w_is_rtype && (instr_func == c_FN_HLT);
    assign w_is_wwd   = w_is_rtype && (instr_func == c_FN_WWD);
    assign w_is_alu_r = w_is_rtype && (instr_func <= c_FN_SHR);

    // Next-state and output decode. Outputs depend only on the current state
    // and inputs; everything is forced low while reset is held so that the
    // fetch request does not leak out of the reset window.
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        i_readM     = 1'b0;
        ir_write    = 1'b0;
        d_readM     = 1'b0;
        d_writeM    = 1'b0;
        alu_opcode  = 4'd0;
        alu_func    = 6'd0;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        pc_write    = 1'b0;
        wwd_en      = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;

        case (r_state)
            c_ST_IF: begin
                i_readM = 1'b1;
                if (i_ready) begin
                    ir_write = 1'b1;
                    w_next   = c_ST_ID;
                end
            end
            c_ST_ID: begin
                if (w_is_hlt) begin
                    w_next = c_ST_HALT;
                end else if (w_is_wwd) begin
                    wwd_en   = 1'b1;
                    pc_write = 1'b1;
                    w_retire = 1'b1;
                    w_next   = c_ST_IF;
                end else if (w_is_alu_r || w_is_imm) begin
                    w_next = c_ST_EX;
                end else begin
                    // Unsupported: skip it without counting a retirement
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                    w_next   = c_ST_IF;
                end
            end
            c_ST_EX: begin
                alu_opcode  = instr_opcode;
                alu_func    = instr_func;
                alu_src_imm = w_is_imm;
                w_next      = (w_is_lwd || w_is_swd) ? c_ST_MEM : c_ST_WB;
            end
            c_ST_MEM: begin
                alu_opcode  = instr_opcode;
                alu_func    = instr_func;
                alu_src_imm = w_is_imm;
                d_readM     = w_is_lwd;
                d_writeM    = w_is_swd;
                if (d_ready) begin
                    if (w_is_lwd) begin
                        w_next = c_ST_WB;
                    end else begin
                        // Store completes here; nothing to write back
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = c_ST_IF;
                    end
                end
            end
            c_ST_WB: begin
                alu_opcode  = instr_opcode;
                alu_func    = instr_func;
                alu_src_imm = w_is_imm;
                reg_write   = 1'b1;
                mem_to_reg  = w_is_lwd;
                pc_write    = 1'b1;
                w_retire    = 1'b1;
                w_next      = c_ST_IF;
            end
            c_ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = c_ST_IF;
            end
        endcase

        if (!reset_n) begin
            w_retire    = 1'b0;
            i_readM     = 1'b0;
            ir_write    = 1'b0;
            d_readM     = 1'b0;
            d_writeM    = 1'b0;
            alu_opcode  = 4'd0;
            alu_func    = 6'd0;
            alu_src_imm = 1'b0;
            reg_write   = 1'b0;
            mem_to_reg  = 1'b0;
            pc_write    = 1'b0;
            wwd_en      = 1'b0;
            illegal     = 1'b0;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_IF;
            r_num_inst <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_num_inst <= r_num_inst + WORD_SIZE'(1);
            end
        end
    end

    assign state    = r_state;
    assign num_inst = r_num_inst;

endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mc_sequencer
// Description : Directed self-checking bench for mc_sequencer. A second
//               instance with a 4-bit counter exercises counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  instr_opcode;
    logic [5:0]  instr_func;
    logic        i_ready;
    logic        d_ready;

    logic        i_readM, ir_write, d_readM, d_writeM;
    logic [3:0]  alu_opcode;
    logic [5:0]  alu_func;
    logic        alu_src_imm, reg_write, mem_to_reg, pc_write, wwd_en, illegal, halted;
    logic [15:0] num_inst;
    logic [2:0]  state;

    logic        w_i_readM, w_ir_write, w_d_readM, w_d_writeM;
    logic [3:0]  w_alu_opcode;
    logic [5:0]  w_alu_func;
    logic        w_alu_src_imm, w_reg_write, w_mem_to_reg, w_pc_write, w_wwd_en, w_illegal, w_halted;
    logic [3:0]  w_num_inst;
    logic [2:0]  w_state;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_num;

    always #5 clk = ~clk;

    mc_sequencer #(.WORD_SIZE(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .instr_opcode(instr_opcode), .instr_func(instr_func),
        .i_ready(i_ready), .d_ready(d_ready), .i_readM(i_readM), .ir_write(ir_write),
        .d_readM(d_readM), .d_writeM(d_writeM), .alu_opcode(alu_opcode), .alu_func(alu_func),
        .alu_src_imm(alu_src_imm), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_write(pc_write), .wwd_en(wwd_en), .illegal(illegal), .halted(halted),
        .num_inst(num_inst), .state(state)
    );

    mc_sequencer #(.WORD_SIZE(4)) u_dut_w (
        .clk(clk), .reset_n(reset_n), .instr_opcode(instr_opcode), .instr_func(instr_func),
        .i_ready(i_ready), .d_ready(d_ready), .i_readM(w_i_readM), .ir_write(w_ir_write),
        .d_readM(w_d_readM), .d_writeM(w_d_writeM), .alu_opcode(w_alu_opcode), .alu_func(w_alu_func),
        .alu_src_imm(w_alu_src_imm), .reg_write(w_reg_write), .mem_to_reg(w_mem_to_reg),
        .pc_write(w_pc_write), .wwd_en(w_wwd_en), .illegal(w_illegal), .halted(w_halted),
        .num_inst(w_num_inst), .state(w_state)
    );

    // Tasks start and end at posedge+1 with the FSM in IF.
    task automatic test_reset();
        logic [14:0] strobes;
        reset_n = 1'b0; i_ready = 1'b1; d_ready = 1'b1;
        instr_opcode = 4'd0; instr_func = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        strobes = {i_readM, ir_write, d_readM, d_writeM, alu_src_imm, reg_write,
                   mem_to_reg, pc_write, wwd_en, illegal, halted, alu_opcode};
        checks++;
        if (strobes !== 15'd0 || alu_func !== 6'd0)
            $display("FAIL reset_outputs: got %h/%h expected 0/0", strobes, alu_func);
        checks++;
        if (state !== 3'd0 || num_inst !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d num=%0d expected 0/0", state, num_inst);
        end
        if (strobes !== 15'd0 || alu_func !== 6'd0) errors++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (i_readM !== 1'b1 || state !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: got i_readM=%0b state=%0d expected 1/0", i_readM, state);
        end
        exp_num = 16'd0;
    endtask

    task automatic test_alu(input logic [3:0] op, input logic [5:0] fn);
        logic [2:0] exp_st [4];
        logic       last, imm;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
        instr_opcode = op; instr_func = fn; i_ready = 1'b1; d_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            last = (c == 3);
            imm  = (c >= 2) && (op != 4'd15);
            checks++;
            if (state !== exp_st[c]) begin
                errors++;
                $display("FAIL alu_state op%0d c%0d: got %0d expected %0d", op, c, state, exp_st[c]);
            end
            checks++;
            if (reg_write !== last || pc_write !== last || ir_write !== (c == 0) || mem_to_reg !== 1'b0) begin
                errors++;
                $display("FAIL alu_strobes op%0d c%0d: got rw=%0b pc=%0b ir=%0b m2r=%0b expected %0b/%0b/%0b/0",
                         op, c, reg_write, pc_write, ir_write, mem_to_reg, last, last, c == 0);
            end
            checks++;
            if (alu_opcode !== ((c >= 2) ? op : 4'd0) || alu_func !== ((c >= 2) ? fn : 6'd0) || alu_src_imm !== imm) begin
                errors++;
                $display("FAIL alu_select op%0d c%0d: got %0d/%0d/%0b expected %0d/%0d/%0b", op, c,
                         alu_opcode, alu_func, alu_src_imm, (c >= 2) ? op : 4'd0, (c >= 2) ? fn : 6'd0, imm);
            end
            @(posedge clk); #1;
        end
        exp_num = exp_num + 16'd1;
        checks++;
        if (num_inst !== exp_num || state !== 3'd0) begin
            errors++;
            $display("FAIL alu_retire op%0d: got num=%0d state=%0d expected %0d/0", op, num_inst, state, exp_num);
        end
    endtask

    task automatic test_lwd();
        logic [2:0] exp_st [8];
        logic [7:0] drdy, exp_rd;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        drdy   = 8'b0100_0111;   // bit c = d_ready in cycle c; early ones must be ignored
        exp_rd = 8'b0111_1000;
        instr_opcode = 4'd7; instr_func = 6'd3; i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            d_ready = drdy[c];
            @(negedge clk);
            checks++;
            if (state !== exp_st[c] || d_readM !== exp_rd[c] || d_writeM !== 1'b0) begin
                errors++;
                $display("FAIL lwd_mem c%0d: got state=%0d rd=%0b wr=%0b expected %0d/%0b/0",
                         c, state, d_readM, d_writeM, exp_st[c], exp_rd[c]);
            end
            checks++;
            if (reg_write !== (c == 7) || mem_to_reg !== (c == 7) || pc_write !== (c == 7) || alu_src_imm !== (c >= 2)) begin
                errors++;
                $display("FAIL lwd_wb c%0d: got rw=%0b m2r=%0b pc=%0b imm=%0b expected %0b/%0b/%0b/%0b",
                         c, reg_write, mem_to_reg, pc_write, alu_src_imm, c == 7, c == 7, c == 7, c >= 2);
            end
            @(posedge clk); #1;
        end
        d_ready = 1'b0;
        exp_num = exp_num + 16'd1;
        checks++;
        if (num_inst !== exp_num || state !== 3'd0) begin
            errors++;
            $display("FAIL lwd_retire: got num=%0d state=%0d expected %0d/0", num_inst, state, exp_num);
        end
    endtask

    task automatic test_swd();
        logic [2:0] exp_st [4];
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3};
        instr_opcode = 4'd8; instr_func = 6'd0; i_ready = 1'b1; d_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (state !== exp_st[c] || d_writeM !== (c == 3) || d_readM !== 1'b0) begin
                errors++;
                $display("FAIL swd_mem c%0d: got state=%0d wr=%0b rd=%0b expected %0d/%0b/0",
                         c, state, d_writeM, d_readM, exp_st[c], c == 3);
            end
            checks++;
            if (pc_write !== (c == 3) || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL swd_strobes c%0d: got pc=%0b rw=%0b expected %0b/0", c, pc_write, reg_write, c == 3);
            end
            @(posedge clk); #1;
        end
        exp_num = exp_num + 16'd1;
        checks++;
        if (num_inst !== exp_num || state !== 3'd0) begin
            errors++;
            $display("FAIL swd_retire: got num=%0d state=%0d expected %0d/0", num_inst, state, exp_num);
        end
    endtask

    task automatic test_wwd_illegal();
        logic [3:0] ops [3];
        logic [5:0] fns [3];
        ops = '{4'd15, 4'd9, 4'd15};
        fns = '{6'd28, 6'd0, 6'd25};   // WWD, JMP, JPR
        i_ready = 1'b1; d_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            instr_opcode = ops[k]; instr_func = fns[k];
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                checks++;
                if (state !== c[2:0] || pc_write !== (c == 1) ||
                    wwd_en !== (c == 1 && k == 0) || illegal !== (c == 1 && k != 0)) begin
                    errors++;
                    $display("FAIL wwd_ill k%0d c%0d: got st=%0d pc=%0b wwd=%0b ill=%0b expected %0d/%0b/%0b/%0b",
                             k, c, state, pc_write, wwd_en, illegal, c, c == 1, c == 1 && k == 0, c == 1 && k != 0);
                end
                @(posedge clk); #1;
            end
            if (k == 0) exp_num = exp_num + 16'd1;
            checks++;
            if (num_inst !== exp_num || state !== 3'd0) begin
                errors++;
                $display("FAIL wwd_ill_count k%0d: got num=%0d state=%0d expected %0d/0", k, num_inst, state, exp_num);
            end
        end
    endtask

    task automatic test_iready_wait();
        instr_opcode = 4'd15; instr_func = 6'd28; i_ready = 1'b0; d_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd0 || i_readM !== 1'b1 || ir_write !== 1'b0) begin
                errors++;
                $display("FAIL iready_wait c%0d: got st=%0d ird=%0b ir=%0b expected 0/1/0", c, state, i_readM, ir_write);
            end
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ir_write !== 1'b1) begin
            errors++;
            $display("FAIL iready_load: got ir_write=%0b expected 1", ir_write);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_num = exp_num + 16'd1;
        checks++;
        if (num_inst !== exp_num || state !== 3'd0) begin
            errors++;
            $display("FAIL iready_retire: got num=%0d state=%0d expected %0d/0", num_inst, state, exp_num);
        end
    endtask

    task automatic test_reset_mid_mem();
        instr_opcode = 4'd7; instr_func = 6'd0; i_ready = 1'b1; d_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (state !== 3'd3 || d_readM !== 1'b1) begin
            errors++;
            $display("FAIL midmem_enter: got st=%0d rd=%0b expected 3/1", state, d_readM);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || d_readM !== 1'b0 || num_inst !== 16'd0) begin
            errors++;
            $display("FAIL midmem_abort: got st=%0d rd=%0b num=%0d expected 0/0/0", state, d_readM, num_inst);
        end
        exp_num = 16'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_halt();
        instr_opcode = 4'd15; instr_func = 6'd29; i_ready = 1'b1; d_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd5 || halted !== 1'b1 || i_readM !== 1'b0 || pc_write !== 1'b0 ||
                ir_write !== 1'b0 || num_inst !== exp_num) begin
                errors++;
                $display("FAIL halt c%0d: got st=%0d h=%0b ird=%0b pc=%0b num=%0d expected 5/1/0/0/%0d",
                         c, state, halted, i_readM, pc_write, num_inst, exp_num);
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || halted !== 1'b0 || num_inst !== 16'd0) begin
            errors++;
            $display("FAIL halt_reset: got st=%0d h=%0b num=%0d expected 0/0/0", state, halted, num_inst);
        end
        exp_num = 16'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_wrap();
        instr_opcode = 4'd15; instr_func = 6'd0; i_ready = 1'b1; d_ready = 1'b0;
        repeat (15 * 4) @(posedge clk);
        #1;
        exp_num = exp_num + 16'd15;
        checks++;
        if (w_num_inst !== 4'hF || num_inst !== exp_num) begin
            errors++;
            $display("FAIL wrap_full: got %0d/%0d expected 15/%0d", w_num_inst, num_inst, exp_num);
        end
        repeat (4) @(posedge clk);
        #1;
        exp_num = exp_num + 16'd1;
        checks++;
        if (w_num_inst !== 4'h0 || num_inst !== exp_num || w_state !== 3'd0) begin
            errors++;
            $display("FAIL wrap_zero: got %0d/%0d st=%0d expected 0/%0d/0", w_num_inst, num_inst, w_state, exp_num);
        end
    endtask

    initial begin
        test_reset();
        test_alu(4'd15, 6'd0);   // ADD
        test_alu(4'd15, 6'd7);   // SHR
        test_alu(4'd4,  6'd2);   // ADI
        test_lwd();
        test_swd();
        test_wwd_illegal();
        test_iready_wait();
        test_reset_mid_mem();
        test_alu(4'd6, 6'd0);    // LHI
        test_halt();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter: WORD_SIZE, 16, width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 instr_opcode  in  4  opcode field of the instruction register; valid from ID until the instruction retires.
REQ-005 instr_func  in  6  func field of the instruction register; same validity as instr_opcode.
REQ-006 i_ready  in  1  instruction-cache completion; sampled only in IF.
REQ-007 d_ready  in  1  data-cache completion; sampled only in MEM.
REQ-008 i_readM  out  1  instruction fetch request.
REQ-009 ir_write  out  1  instruction-register load strobe.
REQ-010 d_readM / d_writeM  out  1 each  data read / write request.
REQ-011 alu_opcode  out  4  and alu_func  out  6: ALU operation select.
REQ-012 alu_src_imm  out  1  ALU B operand: 1 = sign/zero-extended immediate, 0 = register.
REQ-013 reg_write  out  1  register-file write strobe; mem_to_reg  out  1  write-back source, 1 = load data.
REQ-014 pc_write  out  1  PC advance strobe; wwd_en  out  1  output-port latch strobe; illegal  out  1  unsupported-instruction pulse.
REQ-015 halted  out  1  CPU halted; num_inst  out  WORD_SIZE  retired-instruction count; state  out  3  current state.

Function
REQ-016 States, encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; state register only; all outputs combinational from state and inputs.
REQ-017 Decoded values: ADI=4, ORI=5, LHI=6, LWD=7, SWD=8, R-type=15; R-type func ADD=0, SUB=1, AND=2, ORR=3, NOT=4, TCP=5, SHL=6, SHR=7, JPR=25, JRL=26, WWD=28, HLT=29.
REQ-018 IF: i_readM=1; on i_ready=1 -> ir_write=1 in that cycle, next state ID; else stay IF.
REQ-019 ID: HLT -> HALT; WWD -> wwd_en=1, pc_write=1, retire, -> IF; R-type func 0-7 or opcode 4-8 -> EX; anything else (opcodes 0-3, 9-14, JPR, JRL, other func) -> illegal=1, pc_write=1, no retire, -> IF.
REQ-020 EX, MEM, WB: alu_opcode=instr_opcode, alu_func=instr_func; alu_src_imm=1 for opcodes 4-8, else 0; all three are 0 in IF, ID, HALT.
REQ-021 EX: LWD or SWD -> MEM; otherwise -> WB; no strobes asserted.
REQ-022 MEM: d_readM=1 for LWD, d_writeM=1 for SWD, held until d_ready=1; on d_ready LWD -> WB, SWD -> pc_write=1, retire, -> IF.
REQ-023 WB: reg_write=1, mem_to_reg=1 only for LWD, pc_write=1, retire, -> IF.
REQ-024 HALT: halted=1, all other strobes and requests 0; exit only via reset.
REQ-025 Retire increments num_inst by 1 at the clock edge leaving the retiring state; WORD_SIZE-bit, wraps all-ones -> 0.
REQ-026 Latency with zero-wait caches: R-type/ADI/ORI/LHI = 4 cycles (IF ID EX WB), LWD = 5, SWD = 4, WWD = 2, illegal = 2.
REQ-027 i_ready outside IF and d_ready outside MEM have no effect; d_ready in the first MEM cycle completes the access in that cycle.
REQ-028 Every strobe (ir_write, reg_write, pc_write, wwd_en, illegal) is at most one cycle per instruction; pc_write exactly once per non-halt instruction.

Reset
REQ-029 reset_n=0 forces state=IF and num_inst=0 immediately, regardless of current state or pending cache access.
REQ-030 While reset_n=0 every output is 0, including i_readM; on release i_readM=1 in the same cycle with no extra idle cycle.
REQ-031 Reset asserted mid-MEM drops d_readM/d_writeM immediately; no retire is counted for the aborted instruction.

Verification
REQ-032 Reset release, i_ready=1 every cycle, ADD (op 15, func 0) -> state 0,1,2,4,0; reg_write and pc_write high in cycle 4 only; num_inst=1.
REQ-033 LWD, d_ready held 0 for 3 MEM cycles then 1 -> d_readM high 4 cycles, alu_src_imm=1, then WB with mem_to_reg=1; total 8 cycles; num_inst+1.
REQ-034 SWD with d_ready=1 on first MEM cycle -> d_writeM 1 cycle, pc_write in MEM, no reg_write, back to IF; 4 cycles.
REQ-035 WWD then opcode 9 (JMP) -> wwd_en pulse in ID of first, illegal pulse in ID of second; num_inst increments only once.
REQ-036 HLT -> state 5, halted=1 for 20 cycles, i_readM=0, num_inst frozen; reset_n pulse low -> state 0, num_inst=0, halted=0.
REQ-037 num_inst preloaded to 0xFFFF via 65535 retired ADDs, one more ADD -> num_inst=0x0000.
